// File: rtl/prescale_tick.sv
// -----------------------------------------------------------------------------
// prescale_tick
//
// Programmable clock-enable generator. Counts advances from 0 up to the active
// terminal value div_cur and, on the wrap back to 0, raises a registered
// one-cycle tick that drives the enable of a downstream (cascaded) counter.
// A new terminal value is offered through a valid/ready handshake into a
// single shadow register and takes effect only at a period boundary (a wrap
// advance, or any edge while the block is stopped), so a period is never cut
// short or stretched by a reload.
//
// Optional build macro:
//   PRESCALE_TICK_CASCADE_EN  - adds the `en` input; advances then also
//                               require en=1 so instances chain tick -> en.
//                               Without it the block advances every edge
//                               while run=1.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   run        in   counting allowed while high; low clears the count
//   div_data   in   [WIDTH] new terminal value (period = div_data + 1)
//   div_valid  in   div_data offered
//   div_ready  out  shadow register empty; load accepted on valid && ready
//   en         in   advance qualifier (PRESCALE_TICK_CASCADE_EN builds only)
//   tick       out  registered one-cycle strobe on every wrap
//   count      out  [WIDTH] current count
// -----------------------------------------------------------------------------
module prescale_tick #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] div_data,
    input  logic             div_valid,
    output logic             div_ready,
`ifdef PRESCALE_TICK_CASCADE_EN
    input  logic             en,
`endif
    output logic             tick,
    output logic [WIDTH-1:0] count
);

    typedef enum logic {
        SH_EMPTY   = 1'b0,
        SH_PENDING = 1'b1
    } sh_state_e;

    sh_state_e        sh_state_q, sh_state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [WIDTH-1:0] div_cur_q,  div_cur_d;
    logic [WIDTH-1:0] shadow_q,   shadow_d;
    logic             tick_q,     tick_d;

    logic             qual;
    logic             advance;
    logic             wrap;

`ifdef PRESCALE_TICK_CASCADE_EN
    assign qual = en;
`else
    assign qual = 1'b1;
`endif

    assign advance = run && qual;
    // The compare uses the old div_cur even on an apply edge; the newly
    // applied value governs the following period.
    assign wrap    = advance && (count_q == div_cur_q);

    // Count and tick next-state.
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (!run) begin
            count_d = '0;
        end else if (advance) begin
            if (wrap) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Shadow FSM next-state. Only one load can be in flight: a new offer is
    // ignored (ready low) until the pending value has been applied.
    always_comb begin
        sh_state_d = sh_state_q;
        shadow_d   = shadow_q;
        div_cur_d  = div_cur_q;
        unique case (sh_state_q)
            SH_EMPTY: begin
                if (div_valid) begin
                    shadow_d   = div_data;
                    sh_state_d = SH_PENDING;
                end
            end
            SH_PENDING: begin
                // Applying only at a wrap (count returns to 0) or while
                // stopped (count held at 0) keeps count <= div_cur even when
                // the divisor shrinks.
                if (wrap || !run) begin
                    div_cur_d  = shadow_q;
                    sh_state_d = SH_EMPTY;
                end
            end
            default: sh_state_d = SH_EMPTY;
        endcase
    end

    // Control state register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            tick_q     <= 1'b0;
            div_cur_q  <= '1;
            sh_state_q <= SH_EMPTY;
        end else begin
            count_q    <= count_d;
            tick_q     <= tick_d;
            div_cur_q  <= div_cur_d;
            sh_state_q <= sh_state_d;
        end
    end

    // NOTE: the shadow is a pure data register; it is only ever read in
    // SH_PENDING, which is entered by writing it, so it needs no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign div_ready = (sh_state_q == SH_EMPTY);
    assign tick      = tick_q;
    assign count     = count_q;

endmodule

// File: doc/prescale_tick.md
# prescale_tick

Programmable clock-enable generator that sits directly upstream of a cascaded mantle counter and drives its `en` input. It divides the clock by a runtime-loadable divisor and emits a one-cycle `tick` on every wrap. This replaces the fixed "fast counter == all-ones" compare with a registered, reprogrammable overflow strobe. The divisor is loaded through a valid/ready handshake and takes effect glitch-free at the next wrap.

## Interface
- `WIDTH`, default 4: width of the internal count and the divisor.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: counting allowed while high; low stops and clears the count.
- `div_data` in WIDTH: new terminal value; period = `div_data`+1 advances.
- `div_valid` in 1: `div_data` offered.
- `div_ready` out 1: shadow register empty; a load is accepted when `div_valid`&&`div_ready`.
- `en` in 1: present only with `PRESCALE_TICK_CASCADE_EN`; advance qualifier.
- `tick` out 1: registered one-cycle strobe, the consumer counter's enable.
- `count` out WIDTH: current count, for observation and cascading.

## Operation
- Registers:
  - `count`.
  - `div_cur`, the active terminal value.
  - `shadow`, plus the shadow FSM state.
  - `tick`.
- Reset values: `count`=0, `div_cur`=2^WIDTH−1, `tick`=0, shadow FSM = EMPTY, `div_ready`=1.
- An advance occurs at an edge where `run`=1 and the qualifier is true. The qualifier is `en` if configured, else constant 1.
- On an advance:
  - If `count`==`div_cur` (wrap): `count`←0 and `tick`←1.
  - Otherwise: `count`←`count`+1 and `tick`←0.
- On any non-advance edge, `tick`←0.
- With `run`=0, `count`←0 and `tick`←0 on every edge.
- Shadow FSM:
  - EMPTY: `div_ready`=1. On `div_valid`, `shadow`←`div_data` and go to PENDING.
  - PENDING: `div_ready`=0. Apply on either condition:
    - a wrap advance;
    - any edge with `run`=0.
  - Apply action: `div_cur`←`shadow`, return to EMPTY.
- Wrap and apply are evaluated on the same edge. The wrap compare uses the old `div_cur`; the new value governs the next period.
- A load accepted while `run`=0 is applied on the following edge.
- `div_data`=0 is legal: `tick` fires after every advance.
- Arithmetic is unsigned WIDTH bits. `count` never exceeds `div_cur`. This holds when a smaller divisor is applied because the apply happens only at wrap, with `count`=0.

## Timing
- `tick` is high for exactly the one cycle after the wrap edge. It is never high for two consecutive cycles unless `div_cur`=0 and advances are continuous.
- Load latency:
  - `div_ready` falls the cycle after acceptance.
  - `div_ready` rises the cycle after apply.
  - At most one load is in flight.
- Reset has priority over everything. `rst` mid-period clears `count` and `tick`, discards a PENDING shadow, and restores `div_cur` to all-ones.
- `run` falling mid-period: `count` is 0 and `tick` is 0 after that edge. No partial-period tick is produced.

## Configuration
- `PRESCALE_TICK_CASCADE_EN`:
  - Defined: port `en` exists and advances require `en`=1. This lets instances be chained as tick→en.
  - Undefined: no `en` port, and the block advances every edge while `run`=1.
- The shadow/apply rules are identical in both builds.

## Test plan
- Default divisor: WIDTH=4, `rst` then `run`=1 continuously.
  - First `tick` appears in the cycle after the 16th edge.
  - Thereafter `tick` fires every 16 cycles.
  - `count` sequence is 0..15.
- Divisor load mid-period: load `div_data`=3 at `count`=5 with default divisor.
  - `div_ready`=0 until the wrap at 15.
  - Following periods are 4 cycles: `count` 0,1,2,3.
  - `div_ready`=1 one cycle after the wrap.
- Zero divisor: load `div_data`=0 with `run`=0, then `run`=1.
  - Apply happens on the next edge.
  - `tick` is high every cycle after the first advance edge.
- Stop and reset mid-period:
  - `run`=0 at `count`=9: `count`=0 and no tick. Resume: the next tick comes a full period later.
  - `rst` with a PENDING load: `div_ready`=1 and `div_cur`=15.
- Cascade build: macro defined, `en` toggling 1,0,1,0 with `div_cur`=3.
  - `tick` every 8 cycles.
  - `count` holds on `en`=0 edges.
